// File: rtl/framebuffer_reader_if.sv
// Framebuffer read port, UART transmit port and frame control/status
// for the framebuffer reader.
interface framebuffer_reader_if;
  logic        start;
  logic [9:0]  addr_x;
  logic [9:0]  addr_y;
  logic        read;
  logic [31:0] data_in;
  logic        rd_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        done_sending;

  // The reader drives requests and bytes.
  modport master (
    input  start, data_in, rd_valid, tx_busy,
    output addr_x, addr_y, read, tx_data, tx_start, busy, done_sending
  );

  // The framebuffer, the UART and the controller face the reader.
  modport slave (
    output start, data_in, rd_valid, tx_busy,
    input  addr_x, addr_y, read, tx_data, tx_start, busy, done_sending
  );
endinterface

// File: rtl/framebuffer_reader.sv
// Reads a 4-bit-per-pixel framebuffer one 32-bit word at a time and streams
// every word to a UART, least-significant byte first.
module framebuffer_reader #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int PIX_PER_WORD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  framebuffer_reader_if.master bus
);

  localparam int WORDS = WIDTH * HEIGHT / PIX_PER_WORD;
  localparam int WI_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_DATA, SEND, TX_ACK, TX_WAIT, NEXT_WORD, DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [WI_W-1:0] word_idx_reg;
  logic [1:0]      byte_idx_reg;
  logic [9:0]      x_reg, y_reg;
  logic [31:0]     buffer_reg;
  logic [7:0]      tx_data_reg;
  logic [10:0]     x_step;

  logic            read_o, tx_start_o, busy_o, done_o;
  logic [9:0]      addr_x_o, addr_y_o;

  // Column/row are tracked incrementally instead of dividing word_idx by
  // WIDTH; one extra bit keeps the end-of-row comparison from wrapping.
  assign x_step = {1'b0, x_reg} + 11'(PIX_PER_WORD);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (bus.start) state_next = REQ;
      REQ:        state_next = WAIT_DATA;
      WAIT_DATA:  if (bus.rd_valid) state_next = SEND;
      SEND:       if (!bus.tx_busy) state_next = TX_ACK;
      // One-cycle ack window: leave whether or not the UART raised busy.
      TX_ACK:     state_next = TX_WAIT;
      TX_WAIT: begin
        if (!bus.tx_busy) state_next = (byte_idx_reg == 2'd3) ? NEXT_WORD : SEND;
      end
      NEXT_WORD:  state_next = (word_idx_reg == LAST_WORD) ? DONE : REQ;
      default:    state_next = IDLE;
    endcase
  end

  // Datapath: word/byte counters, pixel address, shift buffer, tx byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      buffer_reg   <= '0;
      tx_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            word_idx_reg <= '0;
            byte_idx_reg <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
          end
        end
        WAIT_DATA: if (bus.rd_valid) buffer_reg <= bus.data_in;
        // tx_data is loaded on the edge entering TX_ACK, so it is valid for
        // the whole tx_start pulse and holds until the next launch.
        SEND: if (!bus.tx_busy) tx_data_reg <= buffer_reg[7:0];
        TX_WAIT: begin
          if (!bus.tx_busy) begin
            buffer_reg   <= {8'h00, buffer_reg[31:8]};
            byte_idx_reg <= byte_idx_reg + 2'd1;
          end
        end
        NEXT_WORD: begin
          if (word_idx_reg != LAST_WORD) begin
            word_idx_reg <= word_idx_reg + 1'b1;
            byte_idx_reg <= '0;
            if (x_step >= 11'(WIDTH)) begin
              x_reg <= '0;
              y_reg <= y_reg + 10'd1;
            end else begin
              x_reg <= x_step[9:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    read_o     = 1'b0;
    addr_x_o   = '0;
    addr_y_o   = '0;
    tx_start_o = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state_reg)
      REQ, WAIT_DATA: begin
        read_o   = 1'b1;
        addr_x_o = x_reg;
        addr_y_o = y_reg;
      end
      TX_ACK:  tx_start_o = 1'b1;
      IDLE:    busy_o = 1'b0;
      DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.read         = read_o;
  assign bus.addr_x       = addr_x_o;
  assign bus.addr_y       = addr_y_o;
  assign bus.tx_start     = tx_start_o;
  assign bus.tx_data      = tx_data_reg;
  assign bus.busy         = busy_o;
  assign bus.done_sending = done_o;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Testbench for framebuffer_reader: framebuffer and UART models driven from
// one negedge process, scenario tasks compared against a frame-level model.
module tb_framebuffer_reader;

  localparam int W     = 32;
  localparam int H     = 8;
  localparam int PPW   = 8;
  localparam int WORDS = W * H / PPW;
  localparam int BYTES = W * H / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  framebuffer_reader_if bus();

  framebuffer_reader #(.WIDTH(W), .HEIGHT(H), .PIX_PER_WORD(PPW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [WORDS];
  logic [7:0]  byte_q [$];
  logic [9:0]  ax_q [$];
  logic [9:0]  ay_q [$];

  int rd_lo = 0, rd_hi = 0, busy_lo = 2, busy_hi = 2;
  bit hold = 1'b0;
  int spur_req = 0, spur_done = 0;
  int addr_viol = 0, pulse_viol = 0, busy_viol = 0;

  // Framebuffer + UART environment: samples outputs and drives inputs on negedge.
  initial begin
    bit         pending;
    bit         prev_start;
    int         rd_cnt;
    int         uart_cnt;
    int         idx;
    logic [9:0] cap_x, cap_y;
    pending = 0; prev_start = 0; rd_cnt = 0; uart_cnt = 0;
    cap_x = '0; cap_y = '0;
    bus.rd_valid = 1'b0;
    bus.data_in  = '0;
    bus.tx_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 0; uart_cnt = 0; prev_start = 0;
        byte_q.delete(); ax_q.delete(); ay_q.delete();
        bus.rd_valid = 1'b0;
        bus.tx_busy  = hold;
        spur_done    = spur_req;
      end else begin
        if (bus.tx_start) begin
          if (prev_start) pulse_viol++;
          if (bus.tx_busy) busy_viol++;
          byte_q.push_back(bus.tx_data);
          uart_cnt = int'($urandom_range(busy_hi, busy_lo));
        end
        prev_start  = bus.tx_start;
        bus.tx_busy = hold || (uart_cnt > 0);
        if (uart_cnt > 0) uart_cnt--;
        bus.rd_valid = 1'b0;
        if (pending) begin
          if (!bus.read || bus.addr_x != cap_x || bus.addr_y != cap_y) addr_viol++;
          if (rd_cnt == 0) begin
            idx = (int'(cap_y) * W + int'(cap_x)) / PPW;
            bus.rd_valid = 1'b1;
            bus.data_in  = (idx < WORDS) ? mem[idx] : 32'hxxxxxxxx;
            pending = 0;
            $display("rd word x=%0d y=%0d data=%h", cap_x, cap_y, bus.data_in);
          end else begin
            rd_cnt--;
          end
        end else if (bus.read) begin
          cap_x = bus.addr_x;
          cap_y = bus.addr_y;
          ax_q.push_back(cap_x);
          ay_q.push_back(cap_y);
          pending = 1;
          rd_cnt = int'($urandom_range(rd_hi, rd_lo));
        end
        if (spur_req != spur_done) begin
          bus.rd_valid = 1'b1;
          bus.data_in  = 32'hDEADBEEF;
          spur_done    = spur_req;
        end
      end
    end
  end

  // Byte k of the frame: word k/4, least-significant byte first.
  function automatic logic [7:0] exp_byte(int k);
    logic [31:0] wv;
    wv = mem[k / 4] >> (8 * (k % 4));
    return wv[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom();
  endtask

  task automatic wait_bytes(input int n, input int limit, output bit ok);
    for (int i = 0; i < limit && byte_q.size() < n; i++) tick();
    ok = (byte_q.size() >= n);
  endtask

  task automatic wait_done(input int limit, output bit ok);
    for (int i = 0; i < limit && !bus.done_sending; i++) tick();
    ok = bus.done_sending;
  endtask

  task automatic wait_read(input int limit, output bit ok);
    for (int i = 0; i < limit && !bus.read; i++) tick();
    ok = bus.read;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    if ({bus.read, bus.tx_start, bus.busy, bus.done_sending} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {bus.read, bus.tx_start, bus.busy, bus.done_sending});
    end
    checks++;
    if ({bus.addr_x, bus.addr_y} !== 20'd0) begin
      errors++; $display("FAIL reset_addr: got (%0d,%0d) want (0,0)", bus.addr_x, bus.addr_y);
    end
    checks++;
    if (bus.tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data);
    end
    checks++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_read();
    logic [7:0] want [4];
    bit ok;
    want[0] = 8'hAA; want[1] = 8'hBB; want[2] = 8'hCC; want[3] = 8'hDD;
    do_reset();
    fill_random();
    mem[0] = 32'hDDCCBBAA;
    rd_lo = 0; rd_hi = 0; busy_lo = 2; busy_hi = 2;
    pulse_start();
    if (bus.read !== 1'b1) begin
      errors++; $display("FAIL basic_read_req: got %b want 1", bus.read);
    end
    checks++;
    if ({bus.addr_x, bus.addr_y} !== 20'd0) begin
      errors++; $display("FAIL basic_first_addr: got (%0d,%0d) want (0,0)", bus.addr_x, bus.addr_y);
    end
    checks++;
    wait_bytes(4, 200, ok);
    if (!ok) begin
      errors++; $display("FAIL basic_bytes_timeout: got %0d bytes want 4", byte_q.size());
    end
    checks++;
    for (int b = 0; b < 4 && b < byte_q.size(); b++) begin
      if (byte_q[b] !== want[b]) begin
        errors++; $display("FAIL basic_byte%0d: got %h want %h", b, byte_q[b], want[b]);
      end
      checks++;
    end
    wait_read(200, ok);
    if (!ok || bus.addr_x !== 10'd8 || bus.addr_y !== 10'd0) begin
      errors++; $display("FAIL basic_second_addr: got read=%b (%0d,%0d) want read=1 (8,0)", bus.read, bus.addr_x, bus.addr_y);
    end
    checks++;
  endtask

  task automatic test_stalls();
    int av0, pv0, bv0;
    bit ok;
    do_reset();
    fill_random();
    rd_lo = 10; rd_hi = 10; busy_lo = 50; busy_hi = 50;
    av0 = addr_viol; pv0 = pulse_viol; bv0 = busy_viol;
    pulse_start();
    wait_bytes(8, 3000, ok);
    if (!ok || byte_q.size() != 8) begin
      errors++; $display("FAIL stall_byte_count: got %0d want 8", byte_q.size());
    end
    checks++;
    for (int k = 0; k < 8 && k < byte_q.size(); k++) begin
      if (byte_q[k] !== exp_byte(k)) begin
        errors++; $display("FAIL stall_byte%0d: got %h want %h", k, byte_q[k], exp_byte(k));
      end
      checks++;
    end
    if (ax_q.size() < 2 || ax_q[1] !== 10'd8 || ay_q[1] !== 10'd0) begin
      errors++; $display("FAIL stall_second_addr: got %0d requests want >=2 with (8,0)", ax_q.size());
    end
    checks++;
    if (addr_viol != av0) begin
      errors++; $display("FAIL stall_addr_stable: got %0d changes want 0", addr_viol - av0);
    end
    checks++;
    if (pulse_viol != pv0 || busy_viol != bv0) begin
      errors++; $display("FAIL stall_tx_start: got %0d long pulses, %0d while busy want 0,0", pulse_viol - pv0, busy_viol - bv0);
    end
    checks++;
    busy_lo = 2; busy_hi = 2; rd_lo = 0; rd_hi = 0;
  endtask

  task automatic test_full_frame();
    int av0, pv0, bv0;
    bit ok;
    do_reset();
    for (int i = 0; i < WORDS; i++) mem[i] = i;
    rd_lo = 0; rd_hi = 3; busy_lo = 0; busy_hi = 4;
    av0 = addr_viol; pv0 = pulse_viol; bv0 = busy_viol;
    pulse_start();
    wait_done(20000, ok);
    if (!ok) begin
      errors++; $display("FAIL frame_done_timeout: got done=%b want 1", bus.done_sending);
    end
    checks++;
    if (byte_q.size() != BYTES) begin
      errors++; $display("FAIL frame_byte_count: got %0d want %0d", byte_q.size(), BYTES);
    end
    checks++;
    for (int k = 0; k < BYTES && k < byte_q.size(); k++) begin
      if (byte_q[k] !== exp_byte(k)) begin
        errors++; $display("FAIL frame_byte%0d: got %h want %h", k, byte_q[k], exp_byte(k));
      end
      checks++;
    end
    if (ax_q.size() != WORDS) begin
      errors++; $display("FAIL frame_req_count: got %0d want %0d", ax_q.size(), WORDS);
    end
    checks++;
    for (int w = 0; w < WORDS && w < ax_q.size(); w++) begin
      if (ax_q[w] !== 10'((w * PPW) % W) || ay_q[w] !== 10'((w * PPW) / W)) begin
        errors++; $display("FAIL frame_addr%0d: got (%0d,%0d) want (%0d,%0d)", w, ax_q[w], ay_q[w], (w * PPW) % W, (w * PPW) / W);
      end
      checks++;
    end
    if (ax_q.size() == 0 || ax_q[ax_q.size()-1] !== 10'(W - PPW) || ay_q[ay_q.size()-1] !== 10'(H - 1)) begin
      errors++; $display("FAIL frame_last_addr: got %0d requests want last (%0d,%0d)", ax_q.size(), W - PPW, H - 1);
    end
    checks++;
    if ({bus.done_sending, bus.busy, bus.read} !== 3'b100) begin
      errors++; $display("FAIL frame_status: got done,busy,read=%b want 100", {bus.done_sending, bus.busy, bus.read});
    end
    checks++;
    if (addr_viol != av0 || pulse_viol != pv0 || busy_viol != bv0) begin
      errors++; $display("FAIL frame_protocol: got %0d/%0d/%0d violations want 0", addr_viol - av0, pulse_viol - pv0, busy_viol - bv0);
    end
    checks++;
  endtask

  task automatic test_start_while_busy();
    bit ok;
    do_reset();
    fill_random();
    rd_lo = 0; rd_hi = 2; busy_lo = 1; busy_hi = 3;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_bytes(8 + i * 20 + int'($urandom_range(7, 0)), 2000, ok);
      repeat ($urandom_range(3, 0)) tick();
      pulse_start();
    end
    wait_done(20000, ok);
    if (!ok || byte_q.size() != BYTES) begin
      errors++; $display("FAIL busy_start_bytes: got done=%b count=%0d want 1/%0d", ok, byte_q.size(), BYTES);
    end
    checks++;
    for (int k = 0; k < BYTES && k < byte_q.size(); k++) begin
      if (byte_q[k] !== exp_byte(k)) begin
        errors++; $display("FAIL busy_start_byte%0d: got %h want %h", k, byte_q[k], exp_byte(k));
      end
      checks++;
    end
    if (ax_q.size() != WORDS) begin
      errors++; $display("FAIL busy_start_reqs: got %0d want %0d", ax_q.size(), WORDS);
    end
    checks++;
    pulse_start();
    if ({bus.done_sending, bus.busy, bus.read} !== 3'b011 || {bus.addr_x, bus.addr_y} !== 20'd0) begin
      errors++; $display("FAIL done_restart: got done,busy,read=%b (%0d,%0d) want 011 (0,0)", {bus.done_sending, bus.busy, bus.read}, bus.addr_x, bus.addr_y);
    end
    checks++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    fill_random();
    rd_lo = 0; rd_hi = 1; busy_lo = 3; busy_hi = 3;
    pulse_start();
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      tick();
      ok = bus.tx_start && (byte_q.size() == 80);
    end
    if (!ok) begin
      errors++; $display("FAIL midreset_reach_word20: got %0d bytes want 80", byte_q.size());
    end
    checks++;
    tick();
    reset = 1'b1;
    #1;
    if ({bus.read, bus.tx_start, bus.busy, bus.done_sending, bus.tx_data, bus.addr_x, bus.addr_y} !== 32'd0) begin
      errors++; $display("FAIL midreset_outputs: got read=%b txs=%b busy=%b done=%b txd=%h (%0d,%0d) want all 0",
                         bus.read, bus.tx_start, bus.busy, bus.done_sending, bus.tx_data, bus.addr_x, bus.addr_y);
    end
    checks++;
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    if (byte_q.size() != 0 || ax_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet: got %0d bytes %0d reads busy=%b want 0 0 0", byte_q.size(), ax_q.size(), bus.busy);
    end
    checks++;
    pulse_start();
    if (bus.read !== 1'b1 || {bus.addr_x, bus.addr_y} !== 20'd0) begin
      errors++; $display("FAIL midreset_restart: got read=%b (%0d,%0d) want 1 (0,0)", bus.read, bus.addr_x, bus.addr_y);
    end
    checks++;
    wait_bytes(4, 500, ok);
    for (int k = 0; k < 4; k++) begin
      if (k >= byte_q.size() || byte_q[k] !== exp_byte(k)) begin
        errors++; $display("FAIL midreset_byte%0d: got %0d bytes want %h", k, byte_q.size(), exp_byte(k));
      end
      checks++;
    end
  endtask

  task automatic test_spurious_strobe();
    bit ok;
    do_reset();
    fill_random();
    rd_lo = 0; rd_hi = 0; busy_lo = 3; busy_hi = 3;
    pulse_start();
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = bus.tx_start;
    end
    if (!ok) begin
      errors++; $display("FAIL spur_first_tx: got no tx_start want one");
    end
    checks++;
    repeat (4) tick();
    hold = 1'b1;
    spur_req++;
    if ({bus.read, bus.busy, bus.tx_start} !== 3'b010) begin
      errors++; $display("FAIL spur_state: got read,busy,txs=%b want 010", {bus.read, bus.busy, bus.tx_start});
    end
    checks++;
    repeat (5) tick();
    hold = 1'b0;
    wait_bytes(8, 500, ok);
    for (int k = 0; k < 8; k++) begin
      if (k >= byte_q.size() || byte_q[k] !== exp_byte(k)) begin
        errors++; $display("FAIL spur_byte%0d: got %0d bytes want %h", k, byte_q.size(), exp_byte(k));
      end
      checks++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_basic_read();
    test_stalls();
    test_full_frame();
    test_start_while_busy();
    test_reset_mid_frame();
    test_spurious_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
